wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
Writeback end of the MEM/WB pipeline interface. It consumes the registered MEM/WB fields, selects the write-back data and destination register, and commits the result into a 32-entry register file. It serves the two combinational read ports used by ID. It exports the resolved write (enable/addr/data) to the forwarding unit and keeps a retired-write counter for debug.

Parameters:
DATA_W, 32, register/data width
NREG, 32, number of architectural registers (index width = 5)
RA_IDX, 31, destination index when RegDst = 2 (link register $ra)
XP_IDX, 26, destination index when RegDst = 3 (exception PC save, $k0)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low
wb_PC_plus4  in  32  PC+4 of the instruction in WB
wb_Data_Mem_Out  in  32  load data
wb_ALUOut  in  32  ALU result
wb_RegDst  in  2  destination select: 0=Rt, 1=Rd, 2=RA_IDX, 3=XP_IDX
wb_RegWr  in  1  write enable from MEM/WB
wb_MemToReg  in  2  data select: 0=ALUOut, 1=Data_Mem_Out, 2/3=PC_plus4
wb_RegisterRd  in  5  rd field
wb_RegisterRt  in  5  rt field
rd_addr1  in  5  ID read address, port 1
rd_addr2  in  5  ID read address, port 2
rd_data1  out  32  read data, port 1
rd_data2  out  32  read data, port 2
fwd_wr_en  out  1  resolved write valid this cycle
fwd_wr_addr  out  5  resolved destination index
fwd_wr_data  out  32  resolved write data
retire_cnt  out  32  count of committed register writes

Behaviour:
- Reset and clock: reset is synchronous, active-low; clock is clk.
- Destination select (combinational): wb_dst = RegDst 0→Rt, 1→Rd, 2→RA_IDX, 3→XP_IDX.
- Data select (combinational): wb_data = MemToReg 0→ALUOut, 1→Data_Mem_Out, 2 or 3→PC_plus4.
- Write qualification: wr_en = wb_RegWr && (wb_dst != 0) && reset. Register $0 is never written.
- fwd_wr_en/addr/data = wr_en/wb_dst/wb_data. These are combinational, zero latency, and valid in the same cycle as the commit edge.
- Commit: on posedge clk with wr_en=1, regs[wb_dst] <= wb_data. Latency is 1 edge. The value is visible on read ports after that edge (plus same-cycle bypass if enabled).
- Read: rd_dataN = regs[rd_addrN] combinationally. rd_addrN == 0 always returns 0.
- retire_cnt increments by 1 on every edge where wr_en=1. It wraps 0xFFFFFFFF→0 with no flag.
- Reset (reset=0 sampled at posedge):
  - all regs cleared to 0 and retire_cnt cleared to 0;
  - any write presented in the same cycle is dropped;
  - fwd_wr_en = 0 while reset is low.
- Reset outputs: rd_data1/2 = 0 the cycle after reset; fwd_wr_addr/fwd_wr_data follow the inputs (don't-care while fwd_wr_en=0).
- Reset mid-stream: in-flight MEM/WB content is discarded. No partial write occurs.
- Simultaneous: both read ports on the same address return the same data. A read of the address being written returns the old value unless WB_BYPASS_EN is defined.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: rd_dataN = wb_data when wr_en && rd_addrN == wb_dst (addr != 0); otherwise the array value. This is a write-before-read bypass that removes the WB→ID hazard.
- Undefined: there is no internal bypass. The hazard unit must stall or forward for one extra cycle.

Decomposition:
- Shared package: RegDst encodings (REGDST_RT/RD/RA/XP), MemToReg encodings (M2R_ALU/MEM/PC), RA_IDX/XP_IDX defaults, DATA_W.
- One sub-module: wb_regfile_array (2R1W array, $0 hardwired, reset clear). The mux/qualification logic, counter and bypass stay in the top.

Test Plan:
- Reset held 2 cycles, then release; read all 32 addresses → all 0; retire_cnt=0; fwd_wr_en=0 during reset.
- RegWr=1, RegDst=1, Rd=5, MemToReg=0, ALUOut=0x1234 → after edge rd_addr1=5 reads 0x1234; retire_cnt=1; fwd_wr_addr=5 in the commit cycle.
- RegDst=0, Rt=0, RegWr=1, ALUOut=0xFFFF → no write, fwd_wr_en=0, retire_cnt unchanged, rd_addr=0 reads 0.
- RegDst=2, MemToReg=2, PC_plus4=0x00400008 → reg31=0x00400008. RegDst=3, MemToReg=3, PC_plus4=0x80000004 → reg26=0x80000004.
- MemToReg=1, Data_Mem_Out=0xDEADBEEF, Rt=9, RegDst=0, rd_addr2=9 in the same cycle → rd_data2 = 0xDEADBEEF before the edge with WB_BYPASS_EN, old value (0) without it; 0xDEADBEEF after the edge in both builds.
- Write in progress with reset=0 on the same edge → target register stays 0; retire_cnt=0.

Source files
------------

// File: rtl/wb_regfile_stage_pkg.sv
// Shared encodings and defaults for the writeback stage and its register array.
// Imported by wb_regfile_stage and wb_regfile_array.
package wb_regfile_stage_pkg;

    localparam int DATA_W     = 32;
    localparam int NREG       = 32;
    localparam int REG_AW     = 5;
    localparam int RA_IDX_DEF = 31;
    localparam int XP_IDX_DEF = 26;

    typedef enum logic [1:0] {
        REGDST_RT = 2'd0,
        REGDST_RD = 2'd1,
        REGDST_RA = 2'd2,
        REGDST_XP = 2'd3
    } regdst_e;

    // Encoding 3 also selects PC+4; it is handled as the default arm.
    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MEM = 2'd1,
        M2R_PC  = 2'd2
    } m2r_e;

endpackage

// File: rtl/wb_regfile_array.sv
// 2-read/1-write architectural register array with $0 hardwired to zero.
// Synchronous active-low reset clears every entry.
module wb_regfile_array
    import wb_regfile_stage_pkg::*;
#(
    parameter int DATA_W = wb_regfile_stage_pkg::DATA_W,
    parameter int NREG   = wb_regfile_stage_pkg::NREG,
    parameter int AW     = REG_AW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr1,
    input  logic [AW-1:0]     i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data1,
    output logic [DATA_W-1:0] o_rd_data2
);

    logic [DATA_W-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Entry 0 is never written, but the read mux forces zero regardless.
    assign o_rd_data1 = (i_rd_addr1 == '0) ? '0 : r_mem[i_rd_addr1];
    assign o_rd_data2 = (i_rd_addr2 == '0) ? '0 : r_mem[i_rd_addr2];

endmodule

// File: rtl/wb_regfile_stage.sv
// MEM/WB writeback: destination/data select, register commit, ID read ports,
// forwarding export and retired-write counter. Optional macro WB_BYPASS_EN.
module wb_regfile_stage
    import wb_regfile_stage_pkg::*;
#(
    parameter int DATA_W = wb_regfile_stage_pkg::DATA_W,
    parameter int NREG   = wb_regfile_stage_pkg::NREG,
    parameter int RA_IDX = RA_IDX_DEF,
    parameter int XP_IDX = XP_IDX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       wb_PC_plus4,
    input  logic [DATA_W-1:0] wb_Data_Mem_Out,
    input  logic [DATA_W-1:0] wb_ALUOut,
    input  logic [1:0]        wb_RegDst,
    input  logic              wb_RegWr,
    input  logic [1:0]        wb_MemToReg,
    input  logic [4:0]        wb_RegisterRd,
    input  logic [4:0]        wb_RegisterRt,
    input  logic [4:0]        rd_addr1,
    input  logic [4:0]        rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              fwd_wr_en,
    output logic [4:0]        fwd_wr_addr,
    output logic [DATA_W-1:0] fwd_wr_data,
    output logic [31:0]       retire_cnt
);

    logic [4:0]        w_dst;
    logic [DATA_W-1:0] w_data;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_arr_rd1;
    logic [DATA_W-1:0] w_arr_rd2;
    logic [31:0]       r_retire_cnt;

    always_comb begin
        w_dst = wb_RegisterRt;
        case (wb_RegDst)
            REGDST_RT: w_dst = wb_RegisterRt;
            REGDST_RD: w_dst = wb_RegisterRd;
            REGDST_RA: w_dst = 5'(RA_IDX);
            REGDST_XP: w_dst = 5'(XP_IDX);
            default:   w_dst = wb_RegisterRt;
        endcase
    end

    always_comb begin
        w_data = wb_PC_plus4;
        case (wb_MemToReg)
            M2R_ALU: w_data = wb_ALUOut;
            M2R_MEM: w_data = wb_Data_Mem_Out;
            default: w_data = wb_PC_plus4;
        endcase
    end

    // Reset in the qualifier drops any write presented during reset.
    assign w_wr_en = wb_RegWr && (w_dst != 5'd0) && reset;

    assign fwd_wr_en   = w_wr_en;
    assign fwd_wr_addr = w_dst;
    assign fwd_wr_data = w_data;

    wb_regfile_array #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .AW     (5)
    ) u_array (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (w_dst),
        .i_wr_data  (w_data),
        .i_rd_addr1 (rd_addr1),
        .i_rd_addr2 (rd_addr2),
        .o_rd_data1 (w_arr_rd1),
        .o_rd_data2 (w_arr_rd2)
    );

`ifdef WB_BYPASS_EN
    // w_wr_en already excludes $0, so a read of $0 never takes the bypass.
    assign rd_data1 = (w_wr_en && (rd_addr1 == w_dst)) ? w_data : w_arr_rd1;
    assign rd_data2 = (w_wr_en && (rd_addr2 == w_dst)) ? w_data : w_arr_rd2;
`else
    assign rd_data1 = w_arr_rd1;
    assign rd_data2 = w_arr_rd2;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retire_cnt <= 32'd0;
        end else if (w_wr_en) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage: directed cases plus randomized
// traffic checked every cycle against an array-based model of the register file.
module tb_wb_regfile_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wb_PC_plus4, wb_Data_Mem_Out, wb_ALUOut;
    logic [1:0]  wb_RegDst, wb_MemToReg;
    logic        wb_RegWr;
    logic [4:0]  wb_RegisterRd, wb_RegisterRt, rd_addr1, rd_addr2;
    logic [31:0] rd_data1, rd_data2, fwd_wr_data, retire_cnt;
    logic        fwd_wr_en;
    logic [4:0]  fwd_wr_addr;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_on = 1'b0;

`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    wb_regfile_stage dut (
        .clk             (clk),
        .reset           (reset),
        .wb_PC_plus4     (wb_PC_plus4),
        .wb_Data_Mem_Out (wb_Data_Mem_Out),
        .wb_ALUOut       (wb_ALUOut),
        .wb_RegDst       (wb_RegDst),
        .wb_RegWr        (wb_RegWr),
        .wb_MemToReg     (wb_MemToReg),
        .wb_RegisterRd   (wb_RegisterRd),
        .wb_RegisterRt   (wb_RegisterRt),
        .rd_addr1        (rd_addr1),
        .rd_addr2        (rd_addr2),
        .rd_data1        (rd_data1),
        .rd_data2        (rd_data2),
        .fwd_wr_en       (fwd_wr_en),
        .fwd_wr_addr     (fwd_wr_addr),
        .fwd_wr_data     (fwd_wr_data),
        .retire_cnt      (retire_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: architectural register contents and retired-write count.
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;

    function automatic int exp_dst();
        int idx;
        if (wb_RegDst == 2'd0)      idx = int'(wb_RegisterRt);
        else if (wb_RegDst == 2'd1) idx = int'(wb_RegisterRd);
        else if (wb_RegDst == 2'd2) idx = 31;
        else                        idx = 26;
        return idx;
    endfunction

    function automatic logic [31:0] exp_data();
        if (wb_MemToReg == 2'd0) return wb_ALUOut;
        if (wb_MemToReg == 2'd1) return wb_Data_Mem_Out;
        return wb_PC_plus4;
    endfunction

    function automatic bit exp_wen();
        return (wb_RegWr === 1'b1) && (exp_dst() != 0) && (reset === 1'b1);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (BYPASS && exp_wen() && int'(a) == exp_dst()) return exp_data();
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        if (reset !== 1'b1) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
            m_cnt <= 32'd0;
        end else if (exp_wen()) begin
            m_regs[exp_dst()] <= exp_data();
            m_cnt <= m_cnt + 32'd1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, sampled mid-period.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("m_fwd_en", {31'd0, fwd_wr_en}, {31'd0, exp_wen()});
            if (exp_wen()) begin
                chk("m_fwd_addr", {27'd0, fwd_wr_addr}, 32'(exp_dst()));
                chk("m_fwd_data", fwd_wr_data, exp_data());
            end
            chk("m_rd1", rd_data1, exp_rd(rd_addr1));
            chk("m_rd2", rd_data2, exp_rd(rd_addr2));
            chk("m_cnt", retire_cnt, m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wb(input bit we, input logic [1:0] dst, input logic [1:0] m2r,
                          input logic [4:0] rd, input logic [4:0] rt,
                          input logic [31:0] alu, input logic [31:0] mem,
                          input logic [31:0] pc);
        wb_RegWr = we; wb_RegDst = dst; wb_MemToReg = m2r;
        wb_RegisterRd = rd; wb_RegisterRt = rt;
        wb_ALUOut = alu; wb_Data_Mem_Out = mem; wb_PC_plus4 = pc;
    endtask

    initial begin
        reset = 1'b0;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
        // A write held during reset must be dropped.
        set_wb(1'b1, 2'd1, 2'd0, 5'd5, 5'd0, 32'hAAAA_0001, 32'd0, 32'd0);
        #2;
        chk("rst_fwd_en", {31'd0, fwd_wr_en}, 32'd0);
        step();
        cmp_on = 1'b1;
        step();
        chk("rst_fwd_en2", {31'd0, fwd_wr_en}, 32'd0);
        chk("rst_cnt", retire_cnt, 32'd0);
        reset = 1'b1;
        wb_RegWr = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
            #1;
            chk("rst_rd1", rd_data1, 32'd0);
            chk("rst_rd2", rd_data2, 32'd0);
            step();
        end

        // Rd write of ALU result.
        rd_addr1 = 5'd5;
        set_wb(1'b1, 2'd1, 2'd0, 5'd5, 5'd3, 32'h0000_1234, 32'h1, 32'h2);
        #1;
        chk("d1_fwd_en", {31'd0, fwd_wr_en}, 32'd1);
        chk("d1_fwd_addr", {27'd0, fwd_wr_addr}, 32'd5);
        chk("d1_fwd_data", fwd_wr_data, 32'h0000_1234);
        step();
        wb_RegWr = 1'b0;
        #1;
        chk("d1_rd1", rd_data1, 32'h0000_1234);
        chk("d1_cnt", retire_cnt, 32'd1);

        // Write to $0 is suppressed.
        rd_addr1 = 5'd0;
        set_wb(1'b1, 2'd0, 2'd0, 5'd7, 5'd0, 32'h0000_FFFF, 32'h0, 32'h0);
        #1;
        chk("d2_fwd_en", {31'd0, fwd_wr_en}, 32'd0);
        step();
        wb_RegWr = 1'b0;
        #1;
        chk("d2_cnt", retire_cnt, 32'd1);
        chk("d2_rd0", rd_data1, 32'd0);

        // Link and exception-PC destinations.
        set_wb(1'b1, 2'd2, 2'd2, 5'd1, 5'd1, 32'h11, 32'h22, 32'h0040_0008);
        step();
        set_wb(1'b1, 2'd3, 2'd3, 5'd1, 5'd1, 32'h11, 32'h22, 32'h8000_0004);
        step();
        wb_RegWr = 1'b0;
        rd_addr1 = 5'd31; rd_addr2 = 5'd26;
        #1;
        chk("d3_ra", rd_data1, 32'h0040_0008);
        chk("d3_xp", rd_data2, 32'h8000_0004);
        chk("d3_cnt", retire_cnt, 32'd3);

        // Load result to Rt, read on port 2 during the commit cycle.
        rd_addr2 = 5'd9;
        set_wb(1'b1, 2'd0, 2'd1, 5'd4, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'h0);
        #1;
        chk("d4_pre", rd_data2, BYPASS ? 32'hDEAD_BEEF : 32'd0);
        step();
        wb_RegWr = 1'b0;
        #1;
        chk("d4_post", rd_data2, 32'hDEAD_BEEF);
        chk("d4_cnt", retire_cnt, 32'd4);

        // Randomized traffic with occasional mid-stream reset.
        for (int c = 0; c < 600; c++) begin
            set_wb(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
            rd_addr1 = ($urandom_range(0, 3) == 0) ? wb_RegisterRd : 5'($urandom_range(0, 31));
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wb_RegisterRt : 5'($urandom_range(0, 31));
            reset = ($urandom_range(0, 59) != 0);
            step();
        end
        reset = 1'b1;
        wb_RegWr = 1'b0;
        step();

        // Write coincident with reset is discarded.
        set_wb(1'b1, 2'd1, 2'd0, 5'd7, 5'd7, 32'h0000_0055, 32'h0, 32'h0);
        reset = 1'b0;
        rd_addr1 = 5'd7;
        #1;
        chk("d5_fwd_en", {31'd0, fwd_wr_en}, 32'd0);
        step();
        reset = 1'b1;
        wb_RegWr = 1'b0;
        #1;
        chk("d5_rd", rd_data1, 32'd0);
        chk("d5_cnt", retire_cnt, 32'd0);
        step();
        cmp_on = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
